// File: rtl/fir_stream.sv
// Streaming FIR filter with runtime-loadable coefficients and a single time-multiplexed MAC.
// Each accepted sample takes NTAPS MAC cycles and then waits in HOLD until the consumer takes the result.
module fir_stream #(
   parameter int NTAPS  = 9,
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int OUT_W  = 24,
   parameter int SIGNED = 0,
   parameter int SAT    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     coef_wr,
   input  logic [$clog2(NTAPS)-1:0] coef_addr,
   input  logic [COEF_W-1:0]        coef_wdata,
   output logic                     coef_ready,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [OUT_W-1:0]         out_data,
   input  logic                     out_ready
);

   localparam int TAP_W = $clog2(NTAPS);
   localparam int ACC_W = DATA_W + COEF_W + TAP_W + ((SIGNED != 0) ? 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_HOLD
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   dline_q [NTAPS];
   logic [DATA_W-1:0]   dline_d [NTAPS];
   logic [COEF_W-1:0]   coef_q  [NTAPS];
   logic [COEF_W-1:0]   coef_d  [NTAPS];
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [TAP_W-1:0]    tap_q, tap_d;
   logic [OUT_W-1:0]    out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;

   logic [ACC_W-1:0]    x_ext, c_ext, prod, acc_sum;
   logic [OUT_W-1:0]    acc_conv;

   // Operands are widened to the accumulator width first; the low ACC_W bits of the
   // product are exact because the full dot product is sized never to overflow ACC_W.
   always_comb begin
      if (SIGNED != 0) begin
         x_ext = ACC_W'($signed(dline_q[tap_q]));
         c_ext = ACC_W'($signed(coef_q[tap_q]));
      end else begin
         x_ext = ACC_W'(dline_q[tap_q]);
         c_ext = ACC_W'(coef_q[tap_q]);
      end
      prod    = x_ext * c_ext;
      acc_sum = acc_q + prod;
   end

   generate
      if (OUT_W >= ACC_W) begin : g_extend
         always_comb begin
            if (SIGNED != 0) acc_conv = OUT_W'($signed(acc_sum));
            else             acc_conv = OUT_W'(acc_sum);
         end
      end else if (SAT != 0) begin : g_sat
         localparam logic [OUT_W-1:0] UMAX = '1;
         localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
         localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};
         logic [ACC_W-OUT_W:0] top_bits;
         always_comb begin
            // A signed value fits in OUT_W only if everything from bit OUT_W-1 up is one sign.
            top_bits = acc_sum[ACC_W-1:OUT_W-1];
            acc_conv = acc_sum[OUT_W-1:0];
            if (SIGNED != 0) begin
               if (!(&top_bits) && (|top_bits)) acc_conv = acc_sum[ACC_W-1] ? SMIN : SMAX;
            end else if (|acc_sum[ACC_W-1:OUT_W]) begin
               acc_conv = UMAX;
            end
         end
      end else begin : g_wrap
         always_comb acc_conv = acc_sum[OUT_W-1:0];
      end
   endgenerate

   // NOTE: every _d signal gets its hold value first, so no path through this block can infer a latch.
   always_comb begin
      state_d     = state_q;
      dline_d     = dline_q;
      coef_d      = coef_q;
      acc_d       = acc_q;
      tap_d       = tap_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (coef_wr && (int'(coef_addr) < NTAPS)) coef_d[coef_addr] = coef_wdata;
            if (clear) begin
               for (int i = 0; i < NTAPS; i++) dline_d[i] = '0;
            end else if (in_valid) begin
               dline_d[0] = in_data;
               for (int i = 1; i < NTAPS; i++) dline_d[i] = dline_q[i-1];
               acc_d   = '0;
               tap_d   = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_sum;
            if (tap_q == TAP_W'(NTAPS - 1)) begin
               out_data_d  = acc_conv;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end else begin
               tap_d = tap_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the delay line and coefficient store are reset with the rest of the state because
   // a freshly reset filter must produce zero output; this keeps them in flops rather than RAM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         tap_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            dline_q[i] <= '0;
            coef_q[i]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         tap_q       <= tap_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         dline_q     <= dline_d;
         coef_q      <= coef_d;
      end
   end

   assign coef_ready = (state_q == S_IDLE);
   assign in_ready   = (state_q == S_IDLE) && !clear;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;

endmodule

// File: tb/tb_fir_stream.sv
// Scoreboard bench for fir_stream: four instances (default, 16-bit saturating, 16-bit wrapping,
// signed) share one input stream; a dot-product model predicts every instance's result.
module tb_fir_stream;

   localparam int NTAPS = 9;
   localparam logic [7:0] IMP_C [NTAPS] = '{8'd9, 8'd234, 8'd30, 8'd71, 8'd102, 8'd64, 8'd28, 8'd229, 8'd2};

   typedef struct packed {
      logic [23:0] e_def;
      logic [15:0] e_sat;
      logic [15:0] e_wrap;
      logic [23:0] e_sgn;
   } exp_t;

   logic        clk, rst;
   logic        coef_wr, clear, in_valid, out_ready;
   logic [3:0]  coef_addr;
   logic [7:0]  coef_wdata, in_data;
   wire  [3:0]  ov, ir, cr;
   wire  [23:0] d_def, d_sgn;
   wire  [15:0] d_sat, d_wrap;

   exp_t        sb [$];
   logic [7:0]  m_coef [NTAPS];
   logic [7:0]  m_hist [NTAPS];
   int          n_cmp, n_bad, cyc, t_acc;
   logic [23:0] last_def, last_sgn;
   logic [15:0] last_sat, last_wrap;

   fir_stream #(.NTAPS(NTAPS)) u_def (
      .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .coef_ready(cr[0]), .clear(clear), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
      .out_valid(ov[0]), .out_data(d_def), .out_ready(out_ready));
   fir_stream #(.NTAPS(NTAPS), .OUT_W(16), .SAT(1)) u_sat (
      .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .coef_ready(cr[1]), .clear(clear), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
      .out_valid(ov[1]), .out_data(d_sat), .out_ready(out_ready));
   fir_stream #(.NTAPS(NTAPS), .OUT_W(16), .SAT(0)) u_wrap (
      .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .coef_ready(cr[2]), .clear(clear), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]),
      .out_valid(ov[2]), .out_data(d_wrap), .out_ready(out_ready));
   fir_stream #(.NTAPS(NTAPS), .SIGNED(1)) u_sgn (
      .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .coef_ready(cr[3]), .clear(clear), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[3]),
      .out_valid(ov[3]), .out_data(d_sgn), .out_ready(out_ready));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // Shift the sample into the model history and queue what every instance should produce.
   task automatic model_accept(input logic [7:0] x);
      longint su, ss;
      exp_t   e;
      for (int i = NTAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = x;
      su = 0;
      ss = 0;
      for (int k = 0; k < NTAPS; k++) begin
         su += longint'(m_coef[k]) * longint'(m_hist[k]);
         ss += longint'($signed(m_coef[k])) * longint'($signed(m_hist[k]));
      end
      e.e_def  = 24'(su);
      e.e_sat  = (su > 65535) ? 16'hFFFF : 16'(su);
      e.e_wrap = 16'(su);
      e.e_sgn  = 24'(ss);
      sb.push_back(e);
   endtask

   task automatic model_reset();
      for (int k = 0; k < NTAPS; k++) begin
         m_coef[k] = '0;
         m_hist[k] = '0;
      end
      sb.delete();
   endtask

   task automatic write_coef(input int k, input logic [7:0] v);
      coef_wr    = 1'b1;
      coef_addr  = 4'(k);
      coef_wdata = v;
      if (k < NTAPS) m_coef[k] = v;
      @(negedge clk);
      coef_wr = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      for (int k = 0; k < NTAPS; k++) m_hist[k] = '0;
   endtask

   task automatic send(input logic [7:0] x);
      int n;
      n = 0;
      while (ir != 4'hF && n < 100) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (ir !== 4'hF) begin
         $display("FAIL send_ready: in_ready=%b want 1111", ir);
         n_bad++;
      end
      in_valid = 1'b1;
      in_data  = x;
      model_accept(x);
      @(negedge clk);
      t_acc    = cyc;
      in_valid = 1'b0;
   endtask

   // Wait for the result, compare all four instances, optionally stall the consumer, then take it.
   task automatic receive(input int stall);
      exp_t e;
      int   n;
      n = 0;
      e = '0;
      out_ready = (stall == 0);
      while (ov == 4'h0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (ov !== 4'hF) begin
         $display("FAIL out_valid: got %b want 1111", ov);
         n_bad++;
      end
      n_cmp++;
      if (cyc - t_acc != NTAPS) begin
         $display("FAIL latency: got %0d edges want %0d", cyc - t_acc, NTAPS);
         n_bad++;
      end
      n_cmp++;
      if (sb.size() == 0) begin
         $display("FAIL scoreboard: got empty queue want one entry");
         n_bad++;
      end else begin
         e = sb.pop_front();
      end
      n_cmp++;
      if (d_def !== e.e_def) begin
         $display("FAIL data_def: got %0d want %0d", d_def, e.e_def);
         n_bad++;
      end
      n_cmp++;
      if (d_sat !== e.e_sat) begin
         $display("FAIL data_sat16: got %0d want %0d", d_sat, e.e_sat);
         n_bad++;
      end
      n_cmp++;
      if (d_wrap !== e.e_wrap) begin
         $display("FAIL data_wrap16: got %0d want %0d", d_wrap, e.e_wrap);
         n_bad++;
      end
      n_cmp++;
      if (d_sgn !== e.e_sgn) begin
         $display("FAIL data_signed: got %0d want %0d", $signed(d_sgn), $signed(e.e_sgn));
         n_bad++;
      end
      for (int i = 0; i < stall; i++) begin
         coef_wr    = 1'b1;
         coef_addr  = 4'd0;
         coef_wdata = 8'd77;
         in_valid   = 1'b1;
         in_data    = 8'd9;
         @(negedge clk);
         n_cmp++;
         if (ov !== 4'hF || ir !== 4'h0 || cr !== 4'h0 || d_def !== e.e_def || d_sgn !== e.e_sgn) begin
            $display("FAIL hold_%0d: got ov=%b ir=%b cr=%b def=%0d sgn=%0d want 1111 0000 0000 %0d %0d",
                     i, ov, ir, cr, d_def, d_sgn, e.e_def, e.e_sgn);
            n_bad++;
         end
      end
      coef_wr   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ov !== 4'h0 || ir !== 4'hF) begin
         $display("FAIL after_transfer: got ov=%b ir=%b want 0000 1111", ov, ir);
         n_bad++;
      end
      n_cmp++;
      if (d_def !== e.e_def) begin
         $display("FAIL retain: got %0d want %0d", d_def, e.e_def);
         n_bad++;
      end
      last_def  = d_def;
      last_sat  = d_sat;
      last_wrap = d_wrap;
      last_sgn  = d_sgn;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (ov !== 4'h0) begin
         $display("FAIL reset_valid: got %b want 0000", ov);
         n_bad++;
      end
      n_cmp++;
      if (d_def !== 24'd0 || d_sat !== 16'd0 || d_wrap !== 16'd0 || d_sgn !== 24'd0) begin
         $display("FAIL reset_data: got %0d %0d %0d %0d want 0", d_def, d_sat, d_wrap, d_sgn);
         n_bad++;
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ir !== 4'hF || cr !== 4'hF) begin
         $display("FAIL reset_ready: got ir=%b cr=%b want 1111 1111", ir, cr);
         n_bad++;
      end
   endtask

   task automatic test_impulse();
      for (int k = 0; k < NTAPS; k++) write_coef(k, IMP_C[k]);
      for (int i = 0; i < NTAPS; i++) begin
         send((i == 0) ? 8'd1 : 8'd0);
         receive(0);
         n_cmp++;
         if (last_def !== 24'(IMP_C[i])) begin
            $display("FAIL impulse_%0d: got %0d want %0d", i, last_def, IMP_C[i]);
            n_bad++;
         end
      end
   endtask

   // Eleven ones back to back also checks the NTAPS+2 accept spacing.
   task automatic test_back_to_back_step();
      int prev;
      int want [3];
      want = '{9, 243, 273};
      prev = 0;
      for (int i = 0; i < 11; i++) begin
         send(8'd1);
         if (i > 0) begin
            n_cmp++;
            if (t_acc - prev != NTAPS + 2) begin
               $display("FAIL throughput_%0d: got %0d want %0d", i, t_acc - prev, NTAPS + 2);
               n_bad++;
            end
         end
         prev = t_acc;
         receive(0);
         if (i < 3) begin
            n_cmp++;
            if (last_def !== 24'(want[i])) begin
               $display("FAIL step_%0d: got %0d want %0d", i, last_def, want[i]);
               n_bad++;
            end
         end
      end
      n_cmp++;
      if (last_def !== 24'd769) begin
         $display("FAIL step_steady: got %0d want 769", last_def);
         n_bad++;
      end
   endtask

   task automatic test_clear();
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'd50;
      #1;
      n_cmp++;
      if (ir !== 4'h0 || cr !== 4'hF) begin
         $display("FAIL clear_ready: got ir=%b cr=%b want 0000 1111", ir, cr);
         n_bad++;
      end
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < NTAPS; k++) m_hist[k] = '0;
      #1;
      n_cmp++;
      if (ov !== 4'h0 || ir !== 4'hF) begin
         $display("FAIL clear_idle: got ov=%b ir=%b want 0000 1111", ov, ir);
         n_bad++;
      end
      @(negedge clk);
      send(8'd3);
      receive(0);
   endtask

   task automatic test_coef_same_edge();
      coef_wr    = 1'b1;
      coef_addr  = 4'd0;
      coef_wdata = 8'd100;
      in_valid   = 1'b1;
      in_data    = 8'd2;
      m_coef[0]  = 8'd100;
      model_accept(8'd2);
      @(negedge clk);
      t_acc    = cyc;
      coef_wr  = 1'b0;
      in_valid = 1'b0;
      receive(0);
   endtask

   task automatic test_addr_oob();
      write_coef(9, 8'hFF);
      write_coef(15, 8'h55);
      send(8'd1);
      receive(0);
   endtask

   task automatic test_max();
      for (int k = 0; k < NTAPS; k++) write_coef(k, 8'd255);
      for (int i = 0; i < NTAPS + 1; i++) begin
         send(8'd255);
         receive(0);
      end
      n_cmp++;
      if (last_def !== 24'd585225 || last_sat !== 16'd65535 || last_wrap !== 16'd60937 || last_sgn !== 24'd9) begin
         $display("FAIL max_steady: got %0d %0d %0d %0d want 585225 65535 60937 9",
                  last_def, last_sat, last_wrap, last_sgn);
         n_bad++;
      end
   endtask

   task automatic test_signed();
      do_clear();
      for (int k = 1; k < NTAPS; k++) write_coef(k, 8'd0);
      write_coef(0, 8'h80);
      send(8'h80);
      receive(0);
      n_cmp++;
      if (last_sgn !== 24'd16384) begin
         $display("FAIL signed_neg_neg: got %0d want 16384", $signed(last_sgn));
         n_bad++;
      end
      write_coef(0, 8'd127);
      send(8'h80);
      receive(0);
      n_cmp++;
      if (last_sgn !== 24'hFFC080) begin
         $display("FAIL signed_pos_neg: got %0d want -16256", $signed(last_sgn));
         n_bad++;
      end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < NTAPS; k++) write_coef(k, IMP_C[k]);
      send(8'd5);
      receive(20);
      send(8'd1);
      receive(0);
   endtask

   task automatic test_reset_mid_mac();
      send(8'd7);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (ov !== 4'h0 || d_def !== 24'd0 || d_sgn !== 24'd0) begin
         $display("FAIL abort: got ov=%b def=%0d sgn=%0d want 0000 0 0", ov, d_def, d_sgn);
         n_bad++;
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ir !== 4'hF || cr !== 4'hF) begin
         $display("FAIL abort_ready: got ir=%b cr=%b want 1111 1111", ir, cr);
         n_bad++;
      end
      for (int i = 0; i < NTAPS; i++) begin
         send((i == 0) ? 8'd1 : 8'd0);
         receive(0);
         n_cmp++;
         if (last_def !== 24'd0) begin
            $display("FAIL zero_coef_%0d: got %0d want 0", i, last_def);
            n_bad++;
         end
      end
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      cyc        = 0;
      t_acc      = 0;
      rst        = 1'b0;
      coef_wr    = 1'b0;
      coef_addr  = '0;
      coef_wdata = '0;
      clear      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b1;
      model_reset();
      test_reset();
      test_impulse();
      test_back_to_back_step();
      test_clear();
      test_coef_same_edge();
      test_addr_oob();
      test_max();
      test_signed();
      test_backpressure();
      test_reset_mid_mac();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
